// File: rtl/dcf77_encoder_pkg.sv
// Shared definitions for the DCF77 encoder: field layout of the time/date
// word, bit positions inside the 59-bit minute frame, FSM states and the
// frame builder.
package dcf77_encoder_pkg;

  localparam int TD_W      = 44;  // time/date word width
  localparam int SEC_W     = 6;   // second index width
  localparam int FRAME_LEN = 59;  // bits 0..58, index = second

  localparam logic [SEC_W-1:0] GAP_SEC = 6'd59;  // second without a pulse

  // Field LSB offsets inside the time/date word (seconds field sits above Z)
  localparam int TD_Z_LSB    = 35;
  localparam int TD_MIN_LSB  = 28;
  localparam int TD_HOUR_LSB = 22;
  localparam int TD_DAY_LSB  = 16;
  localparam int TD_WDAY_LSB = 13;
  localparam int TD_MON_LSB  = 8;
  localparam int TD_YEAR_LSB = 0;

  // Field widths
  localparam int MIN_W  = 7;
  localparam int HOUR_W = 6;
  localparam int DAY_W  = 6;
  localparam int WDAY_W = 3;
  localparam int MON_W  = 5;
  localparam int YEAR_W = 8;

  // Frame bit indices
  localparam int F_Z1    = 17;
  localparam int F_Z2    = 18;
  localparam int F_START = 20;
  localparam int F_MIN   = 21;
  localparam int F_P1    = 28;
  localparam int F_HOUR  = 29;
  localparam int F_P2    = 35;
  localparam int F_DAY   = 36;
  localparam int F_WDAY  = 42;
  localparam int F_MON   = 45;
  localparam int F_YEAR  = 50;
  localparam int F_P3    = 58;

  typedef enum logic [1:0] {
    ST_IDLE,   // line idle, waiting for enable and data
    ST_GAP,    // second 59: no pulse
    ST_PULSE,  // low part of a second
    ST_HOLD    // high remainder of a second
  } state_t;

  typedef logic [FRAME_LEN-1:0]  frame_t;
  typedef logic [TD_Z_LSB+1:0]   shadow_t;  // time/date word without seconds

  // Assemble one minute frame; all fields LSB first, parities even.
  function automatic frame_t build_frame(input shadow_t td);
    frame_t f;
    f = '0;
    f[F_Z1]              = td[TD_Z_LSB+1];
    f[F_Z2]              = td[TD_Z_LSB];
    f[F_START]           = 1'b1;
    f[F_MIN  +: MIN_W]   = td[TD_MIN_LSB  +: MIN_W];
    f[F_P1]              = ^td[TD_MIN_LSB +: MIN_W];
    f[F_HOUR +: HOUR_W]  = td[TD_HOUR_LSB +: HOUR_W];
    f[F_P2]              = ^td[TD_HOUR_LSB +: HOUR_W];
    f[F_DAY  +: DAY_W]   = td[TD_DAY_LSB  +: DAY_W];
    f[F_WDAY +: WDAY_W]  = td[TD_WDAY_LSB +: WDAY_W];
    f[F_MON  +: MON_W]   = td[TD_MON_LSB  +: MON_W];
    f[F_YEAR +: YEAR_W]  = td[TD_YEAR_LSB +: YEAR_W];
    f[F_P3]              = ^f[F_P3-1:F_DAY];
    return f;
  endfunction

endpackage

// File: rtl/dcf77_encoder_if.sv
// Control/data bundle between the time source and the DCF77 encoder.
interface dcf77_encoder_if;
  import dcf77_encoder_pkg::*;

  logic              enable_in;
  logic [TD_W-1:0]   timeAndDate_in;
  logic              load_in;
  logic              frame_pending_out;
  logic              dcf_out;
  logic [SEC_W-1:0]  second_out;
  logic              bit_value_out;
  logic              minute_start_out;

  modport master (
    output enable_in, timeAndDate_in, load_in,
    input  frame_pending_out, dcf_out, second_out, bit_value_out, minute_start_out
  );

  modport slave (
    input  enable_in, timeAndDate_in, load_in,
    output frame_pending_out, dcf_out, second_out, bit_value_out, minute_start_out
  );
endinterface

// File: rtl/dcf77_encoder_tick_gen.sv
// Cycle prescaler: counts clock cycles within one second and flags the last
// cycle of each second. A synchronous restart holds the count at zero.
module dcf77_encoder_tick_gen #(
  parameter int CLK_FREQ = 10000000,
  localparam int CNT_W   = $clog2(CLK_FREQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  output logic             sec_tick,
  output logic [CNT_W-1:0] cycle
);

  assign sec_tick = (cycle == CNT_W'(CLK_FREQ - 1));

  // Cycle counter, wraps at the end of each second
  // NOTE: registers are written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cycle <= '0;
    else if (restart || sec_tick)
      cycle <= '0;
    else
      cycle <= cycle + 1'b1;
  end

endmodule

// File: rtl/dcf77_encoder.sv
// DCF77 pulse-stream generator: shadow register for the next minute's
// time/date, frame builder, second counter and pulse FSM.
module dcf77_encoder
  import dcf77_encoder_pkg::*;
#(
  parameter int CLK_FREQ = 10000000,
  parameter int LOW0_CYC = CLK_FREQ / 10,
  parameter int LOW1_CYC = CLK_FREQ / 5
) (
  input  logic            clk,
  input  logic            nReset,
  dcf77_encoder_if.slave  bus
);

  localparam int CNT_W = $clog2(CLK_FREQ);

  state_t            state_q, state_d;
  logic [SEC_W-1:0]  second_q, second_d;
  logic [SEC_W-1:0]  next_sec;
  shadow_t           shadow_q;
  frame_t            frame_q;
  logic              pending_q;
  logic              sent_q;
  logic              minute_start_q;
  logic              frame_start;
  logic              restart;
  logic              sec_tick;
  logic [CNT_W-1:0]  cycle;
  logic              cur_bit;
  logic              pulse_end;
  logic              unused_sec;

  // The seconds field of the time/date word is never transmitted.
  assign unused_sec = ^bus.timeAndDate_in[TD_W-1:TD_Z_LSB+2];

  // Prescaler sits at zero while idle so the first GAP is a full second.
  assign restart = (state_q == ST_IDLE);

  dcf77_encoder_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk      (clk),
    .rst_n    (nReset),
    .restart  (restart),
    .sec_tick (sec_tick),
    .cycle    (cycle)
  );

  assign cur_bit   = frame_q[second_q];
  assign pulse_end = (cycle == (cur_bit ? CNT_W'(LOW1_CYC - 1) : CNT_W'(LOW0_CYC - 1)));
  assign next_sec  = second_q + 1'b1;

  // Next-state and second-counter logic
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    second_d    = second_q;
    frame_start = 1'b0;
    if (!bus.enable_in) begin
      state_d  = ST_IDLE;
      second_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q || sent_q) begin
            state_d  = ST_GAP;
            second_d = GAP_SEC;
          end
        end
        ST_GAP: begin
          if (sec_tick) begin
            state_d     = ST_PULSE;
            second_d    = '0;
            frame_start = 1'b1;
          end
        end
        ST_PULSE: begin
          if (pulse_end)
            state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (sec_tick) begin
            second_d = next_sec;
            state_d  = (next_sec == GAP_SEC) ? ST_GAP : ST_PULSE;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          second_d = '0;
        end
      endcase
    end
  end

  // FSM state, second counter and minute-start strobe
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q        <= ST_IDLE;
      second_q       <= '0;
      minute_start_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      second_q       <= second_d;
      minute_start_q <= frame_start;
    end
  end

  // Shadow register and pending flag; a load beats the frame-start clear
  // NOTE: the wide data registers are reset too, so a frame after reset is all-zero data.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      shadow_q  <= '0;
      pending_q <= 1'b0;
    end else if (bus.load_in) begin
      shadow_q  <= bus.timeAndDate_in[TD_Z_LSB+1:0];
      pending_q <= 1'b1;
    end else if (frame_start) begin
      pending_q <= 1'b0;
    end
  end

  // Frame register is frozen for the whole minute once built
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      frame_q <= '0;
      sent_q  <= 1'b0;
    end else if (frame_start) begin
      frame_q <= build_frame(shadow_q);
      sent_q  <= 1'b1;
    end
  end

  assign bus.dcf_out           = (state_q != ST_PULSE);
  assign bus.second_out        = second_q;
  assign bus.bit_value_out     = ((state_q == ST_PULSE) || (state_q == ST_HOLD)) && cur_bit;
  assign bus.minute_start_out  = minute_start_q;
  assign bus.frame_pending_out = pending_q;

endmodule

// File: tb/tb_dcf77_encoder.sv
// Self-checking bench for dcf77_encoder at CLK_FREQ=500 (LOW0=50, LOW1=100).
// A time-based model predicts the line every cycle; directed checks pin
// hand-computed pulse lengths, GAP length and frame period.
module tb_dcf77_encoder;

  localparam int CLK_FREQ  = 500;
  localparam int LOW0      = 50;
  localparam int LOW1      = 100;
  localparam int FRAME_CYC = 60 * CLK_FREQ;

  // {sec, Z1Z2, min, hour, day, wday, mon, year}
  localparam logic [43:0] T1 = {7'h21, 2'b10, 7'h34, 6'h12, 6'h19, 3'd4, 5'h07, 8'h18};
  localparam logic [43:0] T2 = {7'h05, 2'b01, 7'h35, 6'h12, 6'h19, 3'd4, 5'h07, 8'h18};

  logic clk;
  logic rst_n;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  dcf77_encoder_if bus ();

  dcf77_encoder #(
    .CLK_FREQ (CLK_FREQ),
    .LOW0_CYC (LOW0),
    .LOW1_CYC (LOW1)
  ) dut (
    .clk    (clk),
    .nReset (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit odd_ones(input logic [63:0] v);
    return ($countones(v) % 2) == 1;
  endfunction

  function automatic logic [58:0] model_frame(input logic [43:0] td);
    logic [58:0] f;
    f = '0;
    f[17] = td[36];
    f[18] = td[35];
    f[20] = 1'b1;
    for (int i = 0; i < 7; i++) f[21 + i] = td[28 + i];
    f[28] = odd_ones(64'(td[34:28]));
    for (int i = 0; i < 6; i++) f[29 + i] = td[22 + i];
    f[35] = odd_ones(64'(td[27:22]));
    for (int i = 0; i < 6; i++) f[36 + i] = td[16 + i];
    for (int i = 0; i < 3; i++) f[42 + i] = td[13 + i];
    for (int i = 0; i < 5; i++) f[45 + i] = td[8 + i];
    for (int i = 0; i < 8; i++) f[50 + i] = td[i];
    f[58] = odd_ones(64'(f[57:36]));
    return f;
  endfunction

  // Model: while active, time t counts cycles since the start of transmission;
  // each minute is a 1 s gap (second 59) followed by seconds 0..58.
  bit          m_active;
  int          m_t;
  bit          m_sent;
  bit          m_pend;
  logic [43:0] m_shadow;
  logic [58:0] m_frame;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_sent   <= 1'b0;
      m_pend   <= 1'b0;
      m_shadow <= '0;
      m_frame  <= '0;
    end else begin
      if (m_active) begin
        if (!bus.enable_in) begin
          m_active <= 1'b0;
          m_t      <= 0;
        end else begin
          m_t <= m_t + 1;
          if ((m_t + 1) % FRAME_CYC == CLK_FREQ) begin
            m_frame <= model_frame(m_shadow);
            m_sent  <= 1'b1;
            m_pend  <= 1'b0;
          end
        end
      end else if (bus.enable_in && (m_pend || m_sent)) begin
        m_active <= 1'b1;
        m_t      <= 0;
      end
      if (bus.load_in) begin
        m_shadow <= bus.timeAndDate_in;
        m_pend   <= 1'b1;
      end
    end
  end

  // Per-cycle comparison of all outputs against the model
  int p, s, c;
  bit e_dcf, e_bit, e_ms;
  int e_sec;
  always @(negedge clk) begin
    if (rst_n) begin
      e_dcf = 1'b1; e_bit = 1'b0; e_ms = 1'b0; e_sec = 0;
      if (m_active) begin
        p = m_t % FRAME_CYC;
        if (p < CLK_FREQ) begin
          e_sec = 59;
        end else begin
          s = (p - CLK_FREQ) / CLK_FREQ;
          c = (p - CLK_FREQ) % CLK_FREQ;
          e_sec = s;
          e_bit = m_frame[s];
          e_dcf = (c >= (e_bit ? LOW1 : LOW0));
          e_ms  = (s == 0) && (c == 0);
        end
      end
      n_cmp++;
      if (bus.dcf_out !== e_dcf || int'(bus.second_out) != e_sec || bus.bit_value_out !== e_bit ||
          bus.minute_start_out !== e_ms || bus.frame_pending_out !== m_pend) begin
        n_fail++;
        $display("FAIL cycle_check @%0d: got dcf=%0b sec=%0d bit=%0b ms=%0b pend=%0b, expected dcf=%0b sec=%0d bit=%0b ms=%0b pend=%0b",
                 cyc, bus.dcf_out, bus.second_out, bus.bit_value_out, bus.minute_start_out,
                 bus.frame_pending_out, e_dcf, e_sec, e_bit, e_ms, m_pend);
      end
    end
  end

  // Pulse-length monitor: low run length recorded per second index
  int low_len [60];
  int low_run = 0;
  int low_sec = 0;
  int pulses  = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      low_run = 0;
    end else if (bus.dcf_out == 1'b0) begin
      low_run++;
      low_sec = int'(bus.second_out);
    end else if (low_run != 0) begin
      low_len[low_sec] = low_run;
      pulses++;
      low_run = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [43:0] v);
    @(posedge clk); #1;
    bus.timeAndDate_in = v;
    bus.load_in        = 1'b1;
    @(posedge clk); #1;
    bus.load_in        = 1'b0;
  endtask

  task automatic wait_sec(input int sec, input bit need_low, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (int'(bus.second_out) == sec && (!need_low || bus.dcf_out == 1'b0)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_sec%0d: not reached within %0d cycles", sec, budget);
    end
  endtask

  task automatic wait_ms(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.minute_start_out == 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL wait_minute_start: none within %0d cycles", budget);
    end
  endtask

  // Hand-computed low lengths: minute 0x34 LSB first, and 0x35 for frame 2
  int exp_min1 [7] = '{LOW0, LOW0, LOW1, LOW0, LOW1, LOW1, LOW0};
  int exp_min2 [7] = '{LOW1, LOW0, LOW1, LOW0, LOW1, LOW1, LOW0};

  int en_cyc, ms1, ms2, ms3, p0, tmp;

  initial begin
    rst_n              = 1'b0;
    bus.enable_in      = 1'b0;
    bus.load_in        = 1'b0;
    bus.timeAndDate_in = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_dcf", bus.dcf_out, 1);
    check("rst_second", bus.second_out, 0);
    check("rst_bit", bus.bit_value_out, 0);
    check("rst_minute_start", bus.minute_start_out, 0);
    check("rst_pending", bus.frame_pending_out, 0);
    rst_n = 1'b1;

    // 1: enabled with nothing loaded stays idle
    @(posedge clk); #1;
    bus.enable_in = 1'b1;
    p0 = pulses;
    repeat (2000) @(posedge clk); #1;
    check("idle_pulses", pulses - p0, 0);
    check("idle_dcf", bus.dcf_out, 1);
    check("idle_second", bus.second_out, 0);

    // 2: first frame with T1
    do_load(T1);
    en_cyc = cyc;
    check("load_pending", bus.frame_pending_out, 1);
    wait_ms(600, ms1);
    check("gap_len", ms1 - en_cyc, CLK_FREQ + 1);
    p0 = pulses;

    // 4: load T2 during second 30; current frame must stay T1
    wait_sec(30, 1'b0, 16000, tmp);
    do_load(T2);
    check("pending_mid_frame", bus.frame_pending_out, 1);
    wait_ms(16000, ms2);
    check("frame_period", ms2 - ms1, FRAME_CYC);
    check("f1_pulse_count", pulses - p0, 59);
    check("pending_clear_s0", bus.frame_pending_out, 0);
    check("f1_s0", low_len[0], LOW0);
    check("f1_s17_z1", low_len[17], LOW1);
    check("f1_s18_z2", low_len[18], LOW0);
    check("f1_s19", low_len[19], LOW0);
    check("f1_s20", low_len[20], LOW1);
    for (int i = 0; i < 7; i++) check($sformatf("f1_s%0d_min", 21 + i), low_len[21 + i], exp_min1[i]);
    check("f1_s28_par", low_len[28], LOW1);
    check("f1_s30_hour", low_len[30], LOW1);
    check("f1_s35_par", low_len[35], LOW0);
    check("f1_s58_par", low_len[58], LOW1);

    wait_sec(59, 1'b0, 31000, tmp);
    check("f2_s17_z1", low_len[17], LOW0);
    check("f2_s18_z2", low_len[18], LOW1);
    for (int i = 0; i < 7; i++) check($sformatf("f2_s%0d_min", 21 + i), low_len[21 + i], exp_min2[i]);
    check("f2_s28_par", low_len[28], LOW0);
    check("f2_s58_par", low_len[58], LOW1);

    // 5: disable in the middle of the second-5 pulse, then re-enable
    wait_sec(5, 1'b1, 4000, tmp);
    @(posedge clk); #1;
    bus.enable_in = 1'b0;
    @(negedge clk);
    check("mid_pulse_low", bus.dcf_out, 0);
    @(negedge clk);
    check("abort_dcf", bus.dcf_out, 1);
    check("abort_second", bus.second_out, 0);
    repeat (20) @(posedge clk); #1;
    bus.enable_in = 1'b1;
    en_cyc = cyc;
    wait_ms(600, ms3);
    check("regap_len", ms3 - en_cyc, CLK_FREQ + 1);

    // 6: asynchronous reset mid-second
    wait_sec(2, 1'b0, 1500, tmp);
    do_load(T1);
    check("pending_before_rst", bus.frame_pending_out, 1);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_dcf", bus.dcf_out, 1);
    check("arst_second", bus.second_out, 0);
    check("arst_bit", bus.bit_value_out, 0);
    check("arst_minute_start", bus.minute_start_out, 0);
    check("arst_pending", bus.frame_pending_out, 0);
    repeat (3) @(posedge clk); #1;
    rst_n = 1'b1;
    p0 = pulses;
    repeat (1000) @(posedge clk); #1;
    check("post_rst_pulses", pulses - p0, 0);
    check("post_rst_dcf", bus.dcf_out, 1);
    check("post_rst_second", bus.second_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
